// File: rtl/rv_lsu_pkg.sv
// Shared encodings for the memory-stage load/store unit: funct3 codes,
// FSM states and fault cause codes.
package rv_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_BUSERR   = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  // Access width in bytes encoded by funct3[1:0] (1, 2, 4 or 8).
  function automatic int unsigned access_bytes(input logic [2:0] funct3);
    return 32'd1 << funct3[1:0];
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for a bus master: legality, alignment,
// byte enables, lane-shifted store data and extended load data.
module lsu_lane_align
  import rv_lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                      we,
  input  logic [2:0]                funct3,
  input  logic [$clog2(XLEN/8)-1:0] off,
  input  logic [XLEN-1:0]           wdata,
  input  logic [XLEN-1:0]           rdata,
  output logic                      legal,
  output logic                      aligned,
  output logic [XLEN/8-1:0]         be,
  output logic [XLEN-1:0]           wdata_lane,
  output logic [XLEN-1:0]           rdata_ext
);

  localparam int unsigned NBYTES = XLEN / 8;

  int unsigned       nbytes;
  logic [NBYTES-1:0] mask;
  logic [XLEN-1:0]   wsh;
  logic [XLEN-1:0]   rsh;
  logic              sbit;

  // Decode funct3 into legality/size, then steer data between lanes.
  always_comb begin
    nbytes = access_bytes(funct3);

    case (funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_D:             legal = (XLEN == 64);
      F3_BU, F3_HU:     legal = ~we;
      F3_WU:            legal = ~we & (XLEN == 64);
      default:          legal = 1'b0;
    endcase

    aligned = ((32'(off) & (nbytes - 32'd1)) == 32'd0);

    mask = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      mask[i] = (i < nbytes);
    end
    // Loads always read the whole bus word; the field is extracted below.
    be = we ? (mask << off) : '1;

    wsh = wdata << {off, 3'b000};
    wdata_lane = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (we && be[i]) begin
        wdata_lane[8*i +: 8] = wsh[8*i +: 8];
      end
    end

    rsh  = rdata >> {off, 3'b000};
    sbit = 1'b0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      if (i == 8 * nbytes - 1) begin
        sbit = rsh[i] & ~funct3[2];
      end
    end
    for (int unsigned i = 0; i < XLEN; i++) begin
      rdata_ext[i] = (i < 8 * nbytes) ? rsh[i] : sbit;
    end
  end

endmodule

// File: rtl/lsu_bus_stage.sv
// Memory-stage load/store unit: valid/ready bus master with pipeline stall,
// fault detection and a bounded wait for the bus slave.
module lsu_bus_stage
  import rv_lsu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              stall_o,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_fault,
  output logic [1:0]        rsp_cause,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN/8-1:0] bus_be,
  output logic [XLEN-1:0]   bus_wdata,
  input  logic              bus_ready,
  input  logic [XLEN-1:0]   bus_rdata,
  input  logic              bus_err
);

  localparam int unsigned NBYTES = XLEN / 8;
  localparam int unsigned OFFW   = $clog2(NBYTES);
  localparam int unsigned CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;

  logic              we_q;
  logic [XLEN-1:0]   addr_q;
  logic [NBYTES-1:0] be_q;
  logic [XLEN-1:0]   wdata_q;
  logic [2:0]        f3_q;
  logic [OFFW-1:0]   off_q;

  logic [XLEN-1:0]   rdata_q;
  logic              fault_q;
  logic [1:0]        cause_q;

  logic              sel_we;
  logic [2:0]        sel_f3;
  logic [OFFW-1:0]   sel_off;

  logic              legal, aligned;
  logic [NBYTES-1:0] lane_be;
  logic [XLEN-1:0]   lane_wdata, lane_rdata;

  logic              accept, reject, done, expire;

  // One aligner serves both phases: live request in IDLE, latched request
  // afterwards so load data can be extended when bus_ready arrives.
  always_comb begin
    if (state_q == S_IDLE) begin
      sel_we  = req_we;
      sel_f3  = req_funct3;
      sel_off = req_addr[OFFW-1:0];
    end else begin
      sel_we  = we_q;
      sel_f3  = f3_q;
      sel_off = off_q;
    end
  end

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .we         (sel_we),
    .funct3     (sel_f3),
    .off        (sel_off),
    .wdata      (req_wdata),
    .rdata      (bus_rdata),
    .legal      (legal),
    .aligned    (aligned),
    .be         (lane_be),
    .wdata_lane (lane_wdata),
    .rdata_ext  (lane_rdata)
  );

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    reject    = 1'b0;
    done      = 1'b0;
    expire    = 1'b0;
    stall_o   = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_fault = 1'b0;
    rsp_cause = CAUSE_NONE;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_be    = '0;
    bus_wdata = '0;

    case (state_q)
      S_IDLE: begin
        stall_o = req_valid & rst_n;
        if (req_valid) begin
          if (legal && aligned) begin
            accept  = 1'b1;
            state_d = S_BUSY;
          end else begin
            reject  = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_BUSY: begin
        stall_o   = rst_n;
        bus_req   = 1'b1;
        bus_we    = we_q;
        bus_addr  = addr_q;
        bus_be    = be_q;
        bus_wdata = wdata_q;
        if (bus_ready) begin
          done    = 1'b1;
          state_d = S_RESP;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          expire  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_fault = fault_q;
        rsp_cause = cause_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Wait counter: counts BUSY cycles that end without bus_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == S_BUSY && state_d == S_BUSY) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  // Latch the accepted request so bus outputs stay stable while BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
      be_q    <= lane_be;
      wdata_q <= lane_wdata;
      f3_q    <= req_funct3;
      off_q   <= req_addr[OFFW-1:0];
    end
  end

  // Capture the completion result presented during RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      fault_q <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else if (reject) begin
      rdata_q <= '0;
      fault_q <= 1'b1;
      cause_q <= CAUSE_MISALIGN;
    end else if (done) begin
      if (bus_err) begin
        rdata_q <= '0;
        fault_q <= 1'b1;
        cause_q <= CAUSE_BUSERR;
      end else begin
        rdata_q <= we_q ? '0 : lane_rdata;
        fault_q <= 1'b0;
        cause_q <= CAUSE_NONE;
      end
    end else if (expire) begin
      rdata_q <= '0;
      fault_q <= 1'b1;
      cause_q <= CAUSE_TIMEOUT;
    end
  end

endmodule
